hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Hazard/sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the synchronous hold and clear controls for the PC register and the four stage registers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states and multi-cycle mult/div occupancy.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MD_LAT, 4: mult/div latency in cycles (>=2).
- MEM_TIMEOUT, 64: consecutive MEM wait cycles before mem_err sets.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs of instruction in ID
- id_rt  in  5  rt of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_use_hilo  in  1  ID instruction is mfhi/mflo/mult/div
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  load destination in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_md_start  in  1  EX instruction starts mult/div
- mem_req  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes this cycle
- hold_pc  out  1  hold PC
- hold_if_id  out  1  hold IF/ID register
- clear_if_id  out  1  clear IF/ID register
- hold_id_ex  out  1  hold ID/EX register
- clear_id_ex  out  1  clear ID/EX register
- hold_ex_mem  out  1  hold EX/MEM register
- clear_mem_wb  out  1  clear MEM/WB register
- md_busy  out  1  mult/div unit occupied
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Controls are combinational (Mealy) from registered state plus current inputs, so stage registers act on them at the next clk edge.
- While rst_n = 0:
  - all clear_* = 1 and all hold_* = 0;
  - md_cnt = 0, wait_cnt = 0, mem_err = 0, stall_cnt = 0;
  - FSM in RUN.
- Clear has priority over hold at each stage register.
- Priority order, applied at the same cycle: MEM wait, branch flush, mult/div stall, load-use stall.
- FSM states: RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT -> RUN when mem_ready, or when !mem_req (defensive).
  - A one-cycle access (mem_req && mem_ready) never leaves RUN.
- memstall = mem_req && !mem_ready, in either state. When memstall:
  - hold_pc, hold_if_id, hold_id_ex and hold_ex_mem are all 1;
  - clear_mem_wb = 1 (bubble into WB);
  - every other hazard is suppressed, because its inputs are re-presented next cycle by the held stages.
- wait_cnt:
  - increments each MEM_WAIT cycle, saturating;
  - reaching MEM_TIMEOUT sets mem_err;
  - mem_err clears only on reset;
  - wait_cnt zeroes on return to RUN.
- Branch, when ex_branch_taken && !memstall:
  - clear_if_id = 1 and clear_id_ex = 1;
  - PC is not held.
  - The flush overrides load-use and mult/div stall in the same cycle, because the ID instruction is squashed.
- Mult/div counter md_cnt:
  - loads MD_LAT-1 when ex_md_start && !memstall;
  - otherwise decrements when nonzero, including during memstall;
  - md_busy = (md_cnt != 0).
- Mult/div stall, when md_busy && id_use_hilo && !memstall && !ex_branch_taken:
  - hold_pc = 1 and hold_if_id = 1;
  - clear_id_ex = 1.
- Load-use, when ex_mem_read && ex_rt != 0 && ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt)), and no higher-priority event:
  - same controls as the mult/div stall;
  - lasts exactly one cycle.
- stall_cnt:
  - increments on any cycle with hold_pc = 1;
  - saturates at all-ones.
- Reset asserted mid-stall: all state returns to its reset values immediately (asynchronous), and the outputs follow.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - the register-index width constant (5);
  - the zero-register constant.
- One natural sub-module: sat_counter (parameterised width, inc and clear inputs), used for both stall_cnt and wait_cnt.
- The FSM, md_cnt and the hazard priority logic stay in hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_read = 1, ex_rt = 8, id_rs = 8, id_use_rs = 1 for one cycle -> hold_pc = hold_if_id = clear_id_ex = 1 for exactly that cycle; stall_cnt = 1. Repeat with ex_rt = 0 -> no stall.
2. Branch with load-use in the same cycle: ex_branch_taken = 1 -> clear_if_id = clear_id_ex = 1, hold_pc = 0, stall_cnt unchanged.
3. MEM wait: mem_req = 1, mem_ready = 0 for 3 cycles, then mem_ready = 1 -> hold_pc/if_id/id_ex/ex_mem = 1 and clear_mem_wb = 1 for 3 cycles; FSM returns to RUN; stall_cnt = 3. A concurrent ex_branch_taken is ignored during the wait.
4. Mult/div: ex_md_start pulse, then id_use_hilo = 1 held -> md_busy for MD_LAT-1 = 3 cycles with front-end stall during each of them; released on the 4th cycle.
5. Timeout: mem_req = 1, mem_ready = 0 for 64 cycles -> mem_err = 1 after the 64th and stays set after mem_ready. Asserting rst_n = 0 mid-wait clears mem_err and stall_cnt, and drives all clears = 1 asynchronously.
6. Saturation: with CNT_W = 4, hold a memory stall for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// FSM encodings, register-index width and the hardwired-zero register.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    // True when an enabled source operand names the given destination register.
    function automatic logic src_match(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE_VAL = W'(1);

    // Counter state: async reset, sync clear, increment until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE_VAL;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hold/clear sequencing for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB
// registers: memory wait > branch flush > mult/div stall > load-use stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT      = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_hilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             clear_if_id,
    output logic             hold_id_ex,
    output logic             clear_id_ex,
    output logic             hold_ex_mem,
    output logic             clear_mem_wb,
    output logic             md_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W   = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [MD_W-1:0]   MD_LOAD   = MD_W'(MD_LAT - 1);
    localparam logic [MD_W-1:0]   MD_ONE    = MD_W'(1);
    localparam logic [MD_W-1:0]   MD_ZERO   = MD_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [MD_W-1:0]   md_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              mem_err_r;
    logic              memstall_s;
    logic              branch_s;
    logic              md_stall_s;
    logic              load_use_s;

    assign memstall_s = mem_req && !mem_ready;
    assign branch_s   = ex_branch_taken && !memstall_s;
    assign md_busy    = (md_cnt_r != MD_ZERO);
    assign md_stall_s = md_busy && id_use_hilo && !memstall_s && !ex_branch_taken;
    assign load_use_s = ex_mem_read && (ex_rt != ZERO_REG)
                        && (src_match(id_use_rs, id_rs, ex_rt) || src_match(id_use_rt, id_rt, ex_rt))
                        && !memstall_s && !ex_branch_taken && !md_stall_s;
    assign mem_err    = mem_err_r;

    // Next-state logic for the memory wait FSM.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (memstall_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || !mem_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mult/div occupancy; keeps draining while the pipeline is frozen by memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_r <= MD_ZERO;
        end else if (ex_md_start && !memstall_s) begin
            md_cnt_r <= MD_LOAD;
        end else if (md_cnt_r != MD_ZERO) begin
            md_cnt_r <= md_cnt_r - MD_ONE;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Consecutive wait cycles; the count restarts whenever memory stops stalling.
    sat_counter #(
        .W(WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (memstall_s),
        .clear (!memstall_s),
        .count (wait_cnt_s)
    );

    // Sticky timeout flag, set on the edge that completes the MEM_TIMEOUT-th wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err_r <= 1'b0;
        end else if (memstall_s && (wait_cnt_s >= WAIT_LAST)) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold_pc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    // Prioritised stage controls; reset forces every stage register to clear.
    always_comb begin
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        clear_if_id  = 1'b0;
        hold_id_ex   = 1'b0;
        clear_id_ex  = 1'b0;
        hold_ex_mem  = 1'b0;
        clear_mem_wb = 1'b0;
        if (!rst_n) begin
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
            clear_mem_wb = 1'b1;
        end else if (memstall_s) begin
            hold_pc      = 1'b1;
            hold_if_id   = 1'b1;
            hold_id_ex   = 1'b1;
            hold_ex_mem  = 1'b1;
            clear_mem_wb = 1'b1;
        end else if (branch_s) begin
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
        end else if (md_stall_s || load_use_s) begin
            hold_pc      = 1'b1;
            hold_if_id   = 1'b1;
            clear_id_ex  = 1'b1;
        end else begin
            hold_pc      = 1'b0;
        end
    end

endmodule
